// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified instruction/data RAM between the IF stage
// (instruction fetch) and the MEM stage (lw/sw) of a 5-stage MIPS pipeline.
// Each access owns the RAM for MEM_LATENCY busy cycles, then the owner gets a
// one-cycle ready pulse with registered read data. Stall outputs feed the
// hazard unit (PCWrite / IF/ID write / pipeline freeze).
//
// Optional build macro MEM_ARB_FAIR_EN: when defined, simultaneous requests
// alternate between IF and DM using a last_owner flag. When undefined, the
// MEM stage (older instruction) always wins a tie.
//
// Handshake: a requester raises its request and holds it (with stable
// address/data for the sampling edge) until its ready pulse. Requests are
// sampled only in IDLE; address, write data and write enable are latched at
// grant, so the request inputs may change freely once the access is BUSY.
// Ready is a one-cycle pulse in the DONE cycle and is not back-pressured.

module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  // instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  // data memory port
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  // pipeline stalls
  output logic              stall_if,
  output logic              stall_mem,
  // RAM side
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  // debug view of the sequencer state
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be in 1..15");
  end

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_owner;      // 0 = IF owns the RAM, 1 = DM owns the RAM

  logic       w_dm_req;
  logic       w_any_req;
  logic       w_grant_dm;

  assign w_dm_req  = dm_read | dm_write;
  assign w_any_req = if_req | w_dm_req;

`ifdef MEM_ARB_FAIR_EN
  logic r_last_owner;       // owner of the most recent grant

  // On a tie, grant whoever did not win last time; a lone request always wins.
  assign w_grant_dm = w_dm_req & (~if_req | ~r_last_owner);

  // Remember who was granted so the next tie goes the other way.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_owner <= 1'b0;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_last_owner <= w_grant_dm;
    end
  end
`else
  // The MEM-stage instruction is older, so DM wins any tie.
  assign w_grant_dm = w_dm_req;
`endif

  // Sequencer: arbitrate in IDLE, count the RAM latency in BUSY, pulse ready in DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_owner   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      // pulses default low; ram_addr/ram_wdata/ram_we hold between accesses
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      ram_en   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner   <= w_grant_dm;
            ram_addr  <= w_grant_dm ? dm_addr : if_addr;
            ram_wdata <= dm_wdata;
            // read+write together is treated as a write
            ram_we    <= w_grant_dm & dm_write;
            ram_en    <= 1'b1;
            r_cnt     <= LAT_LOAD;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            // ram_rdata is valid in the last busy cycle; stores leave rdata alone
            if (!ram_we) begin
              if (r_owner) begin
                dm_rdata <= ram_rdata;
              end else begin
                if_rdata <= ram_rdata;
              end
            end
            if (r_owner) begin
              dm_ready <= 1'b1;
            end else begin
              if_ready <= 1'b1;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // no arbitration here; the next request is sampled in IDLE
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // A stage stalls while its request is outstanding, and releases in its ready cycle.
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = w_dm_req & ~dm_ready;

  assign dbg_state = r_state;

  a_one_ready : assert property (@(posedge clock) disable iff (!reset)
    !(if_ready && dm_ready));

  a_en_in_busy : assert property (@(posedge clock) disable iff (!reset)
    ram_en |-> (r_state == S_BUSY));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: table-driven request vectors with a
// scoreboard of expected ready pulses, plus hand-written sequences for reset
// during BUSY and for MEM_LATENCY = 1 and 5.

module tb_mem_port_arbiter;

  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- main DUT (MEM_LATENCY = 2) ----------------
  logic        if_req, dm_read, dm_write;
  logic [31:0] if_addr, dm_addr, dm_wdata, ram_rdata;
  logic [31:0] if_rdata, dm_rdata, ram_addr, ram_wdata;
  logic        if_ready, dm_ready, stall_if, stall_mem, ram_en, ram_we;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) dut (
    .clock(clk), .reset(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // ---------------- latency-variant DUTs ----------------
  logic        lat_if_req;
  logic [31:0] l1_if_rdata, l1_dm_rdata, l1_ram_addr, l1_ram_wdata;
  logic        l1_if_ready, l1_dm_ready, l1_stall_if, l1_stall_mem, l1_ram_en, l1_ram_we;
  logic [1:0]  l1_dbg;
  logic [31:0] l5_if_rdata, l5_dm_rdata, l5_ram_addr, l5_ram_wdata;
  logic        l5_if_ready, l5_dm_ready, l5_stall_if, l5_stall_mem, l5_ram_en, l5_ram_we;
  logic [1:0]  l5_dbg;

  mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut_l1 (
    .clock(clk), .reset(rst_n),
    .if_req(lat_if_req), .if_addr(32'h80), .if_rdata(l1_if_rdata), .if_ready(l1_if_ready),
    .dm_read(1'b0), .dm_write(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
    .dm_rdata(l1_dm_rdata), .dm_ready(l1_dm_ready),
    .stall_if(l1_stall_if), .stall_mem(l1_stall_mem),
    .ram_en(l1_ram_en), .ram_we(l1_ram_we), .ram_addr(l1_ram_addr), .ram_wdata(l1_ram_wdata),
    .ram_rdata(32'h1111_2222), .dbg_state(l1_dbg)
  );

  mem_port_arbiter #(.MEM_LATENCY(5), .ADDR_W(32), .DATA_W(32)) dut_l5 (
    .clock(clk), .reset(rst_n),
    .if_req(lat_if_req), .if_addr(32'h80), .if_rdata(l5_if_rdata), .if_ready(l5_if_ready),
    .dm_read(1'b0), .dm_write(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
    .dm_rdata(l5_dm_rdata), .dm_ready(l5_dm_ready),
    .stall_if(l5_stall_if), .stall_mem(l5_stall_mem),
    .ram_en(l5_ram_en), .ram_we(l5_ram_we), .ram_addr(l5_ram_addr), .ram_wdata(l5_ram_wdata),
    .ram_rdata(32'h3333_4444), .dbg_state(l5_dbg)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- RAM model (main DUT) ----------------
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5EED_0000);
  endfunction

  // Data is presented only in the last busy cycle; other cycles carry junk.
  int bidx = 0;
  always @(negedge clk) begin
    if (ram_en) begin
      bidx = 1;
      if (ram_we) mem[ram_addr] = ram_wdata;
    end else if (bidx != 0) begin
      bidx++;
    end
    if (bidx > LAT) bidx = 0;
    ram_rdata = (bidx == LAT) ? mem_rd(ram_addr) : (32'hBAD0_0000 | 32'(bidx));
  end

  // ---------------- scoreboard ----------------
  // entry = {expected ready cycle[15:0], is_dm, expected rdata}
  logic [48:0] exp_q[$];
  logic [48:0] sb_e;

  function automatic void push(input int c, input logic is_dm, input logic [31:0] d);
    exp_q.push_back({16'(c), is_dm, d});
  endfunction

  always @(negedge clk) begin
    if (if_ready || dm_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", {62'd0, if_ready, dm_ready}, 64'd0);
      end else begin
        sb_e = exp_q.pop_front();
        chk("ready_owner", {62'd0, if_ready, dm_ready}, sb_e[32] ? 64'd1 : 64'd2);
        chk("ready_cycle", 64'(16'(cyc)), 64'(sb_e[48:33]));
        chk(sb_e[32] ? "dm_rdata" : "if_rdata", sb_e[32] ? dm_rdata : if_rdata, sb_e[31:0]);
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_rd;
    logic        dm_wr;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] exp_if;   // fetched word
    logic [31:0] exp_dm;   // loaded word (reads only)
    logic        exp_we;   // ram_we expected for the DM access
  } vec_t;

  vec_t tbl[9];

  // bench-side model of registered outputs and arbitration history
  logic [31:0] m_dm_rdata = 32'h0;
  logic [31:0] m_if_rdata = 32'h0;
  logic        m_last = 1'b0;

  task automatic chk_zero(input string pfx);
    chk({pfx, "_if_rdata"},  if_rdata,  0);
    chk({pfx, "_dm_rdata"},  dm_rdata,  0);
    chk({pfx, "_if_ready"},  if_ready,  0);
    chk({pfx, "_dm_ready"},  dm_ready,  0);
    chk({pfx, "_ram_en"},    ram_en,    0);
    chk({pfx, "_ram_we"},    ram_we,    0);
    chk({pfx, "_ram_addr"},  ram_addr,  0);
    chk({pfx, "_ram_wdata"}, ram_wdata, 0);
    chk({pfx, "_state"},     dbg_state, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int   t0, c, guard;
    int   dm_start, if_start, dm_done, if_done;
    logic dm_any, dm_first, dm_p, if_p;
    dm_any = v.dm_rd | v.dm_wr;
    @(posedge clk); #1;
    if_req = v.if_req; if_addr = v.if_addr;
    dm_read = v.dm_rd; dm_write = v.dm_wr; dm_addr = v.dm_addr; dm_wdata = v.dm_wdata;
    t0 = cyc;
    if (dm_any && v.if_req) begin
`ifdef MEM_ARB_FAIR_EN
      dm_first = ~m_last;
`else
      dm_first = 1'b1;
`endif
    end else begin
      dm_first = dm_any;
    end
    dm_start = dm_first ? 0 : LAT + 2;
    if_start = dm_first ? LAT + 2 : 0;
    if (!dm_any) if_start = 0;
    dm_done = dm_start + LAT + 1;
    if_done = if_start + LAT + 1;
    if (!v.dm_wr) m_dm_rdata = v.exp_dm;
    m_if_rdata = v.exp_if;
    if (dm_first) begin
      push(t0 + dm_done, 1'b1, m_dm_rdata);
      if (v.if_req) push(t0 + if_done, 1'b0, m_if_rdata);
    end else begin
      if (v.if_req) push(t0 + if_done, 1'b0, m_if_rdata);
      if (dm_any) push(t0 + dm_done, 1'b1, m_dm_rdata);
    end
    m_last = (dm_any && v.if_req) ? ~dm_first : dm_any;
    dm_p = dm_any;
    if_p = v.if_req;
    guard = 0;
    while ((dm_p || if_p) && guard < 20) begin
      guard++;
      @(negedge clk);
      c = cyc - t0;
      chk("stall_if",  stall_if,  if_p && (c != if_done));
      chk("stall_mem", stall_mem, dm_p && (c != dm_done));
      if (dm_p && c == dm_start + 1) begin
        chk("dm_ram_en_first", ram_en,   1);
        chk("dm_ram_addr",     ram_addr, v.dm_addr);
        chk("dm_ram_we",       ram_we,   v.exp_we);
      end
      if (dm_p && c == dm_start + 2) begin
        chk("dm_ram_en_second",  ram_en,   0);
        chk("dm_ram_addr_held",  ram_addr, v.dm_addr);
        chk("dm_ram_we_held",    ram_we,   v.exp_we);
        if (v.dm_wr) chk("dm_ram_wdata_held", ram_wdata, v.dm_wdata);
      end
      if (if_p && c == if_start + 1) begin
        chk("if_ram_en_first", ram_en,   1);
        chk("if_ram_addr",     ram_addr, v.if_addr);
        chk("if_ram_we",       ram_we,   0);
      end
      if (if_p && c == if_start + 2) begin
        chk("if_ram_en_second", ram_en,   0);
        chk("if_ram_addr_held", ram_addr, v.if_addr);
      end
      @(posedge clk); #1;
      // scramble the busy owner's inputs: the RAM side must stay latched
      if (dm_p && c >= dm_start && c < dm_done - 1) begin
        dm_addr = $urandom; dm_wdata = $urandom;
      end
      if (if_p && c >= if_start && c < if_done - 1) if_addr = $urandom;
      if (dm_p && c == dm_done) begin dm_read = 0; dm_write = 0; dm_p = 0; end
      if (if_p && c == if_done) begin if_req = 0; if_p = 0; end
    end
    chk("vec_requests_done", {62'd0, dm_p, if_p}, 0);
    chk("vec_scoreboard_drained", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0, c, n_rdy, first1, first5, en5_first, run1, run5, max1, max5;
    logic [31:0] ia, da;

    rst_n = 0; lat_if_req = 0;
    if_req = 0; if_addr = 0; dm_read = 0; dm_write = 0; dm_addr = 0; dm_wdata = 0;

    mem[32'h40]  = 32'h8C22_0004;
    mem[32'h44]  = 32'h2402_0005;
    mem[32'h48]  = 32'h3C01_1001;
    mem[32'h100] = 32'h0000_1234;
    tbl[0] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,         32'h8C22_0004, 32'h0,         1'b0};
    tbl[1] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0,         32'h2402_0005, 32'h0000_1234, 1'b0};
    tbl[2] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h20,  32'hDEAD_BEEF, 32'h0,         32'h0,         1'b1};
    tbl[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h20,  32'h0,         32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h24,  32'hCAFE_F00D, 32'h0,         32'h0,         1'b1};
    tbl[5] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h24,  32'h0,         32'h0,         32'hCAFE_F00D, 1'b0};
    tbl[6] = '{1'b1, 32'h48, 1'b0, 1'b1, 32'h28,  32'h0BAD_F00D, 32'h3C01_1001, 32'h0,         1'b1};
    for (int k = 7; k < 9; k++) begin
      ia = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
      da = 32'h2000 + (32'($urandom_range(0, 255)) << 2);
      mem[ia] = $urandom;
      mem[da] = $urandom;
      tbl[k] = '{1'b1, ia, 1'b1, 1'b0, da, $urandom, mem[ia], mem[da], 1'b0};
    end

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1;

    for (int k = 0; k < 9; k++) run_vec(tbl[k]);

    // reset asserted in the second BUSY cycle of a fetch
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h40;
    t0 = cyc;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_before_reset", dbg_state, 1);
    rst_n = 0;
    #1;
    chk_zero("midreset");
    if_req = 0;
    m_if_rdata = 0; m_dm_rdata = 0; m_last = 0;
    @(posedge clk); #1;
    rst_n = 1;
    n_rdy = 0;
    repeat (6) begin
      @(negedge clk);
      if (if_ready || dm_ready) n_rdy++;
    end
    chk("no_ready_after_reset", n_rdy, 0);
    run_vec(tbl[0]);

    // latency variants: MEM_LATENCY 1 and 5
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    lat_if_req = 1;
    t0 = cyc;
    first1 = -1; first5 = -1; en5_first = -1;
    run1 = 0; run5 = 0; max1 = 0; max5 = 0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      c = cyc - t0;
      if (l1_if_ready && first1 < 0) first1 = c;
      if (l5_if_ready && first5 < 0) first5 = c;
      if (l5_ram_en && en5_first < 0) en5_first = c;
      run1 = l1_ram_en ? run1 + 1 : 0;
      run5 = l5_ram_en ? run5 + 1 : 0;
      if (run1 > max1) max1 = run1;
      if (run5 > max5) max5 = run5;
      @(posedge clk); #1;
      if (c == 6) lat_if_req = 0;
    end
    chk("lat1_ready_cycle", first1, 2);
    chk("lat5_ready_cycle", first5, 6);
    chk("lat5_ram_en_cycle", en5_first, 1);
    chk("lat1_ram_en_width", max1, 1);
    chk("lat5_ram_en_width", max5, 1);
    chk("lat1_if_rdata", l1_if_rdata, 32'h1111_2222);
    chk("lat5_if_rdata", l5_if_rdata, 32'h3333_4444);
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // hard stop if the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
